// File: rtl/ray_sphere_worker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ray_sphere_worker_pkg
// Description : Shared types and constants for the ray/sphere worker. Holds the
//               sphere record, the per-pixel colour code, the FSM encoding,
//               the default batch geometry and the width helper that sizes the
//               discriminant datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package ray_sphere_worker_pkg;

    // Default batch geometry: pixels per start and x distance between jobs.
    localparam int JOBS_SUBDIVISION = 8;
    localparam int N_WORKERS        = 4;

    // Width of each sphere field and of the colour code.
    localparam int SPHERE_COORD_W = 12;
    localparam int COLOR_W        = 8;

    // Sphere centre is signed. The radius is unsigned and is scaled by 8
    // (r << 3) before use.
    typedef struct packed {
        logic signed [SPHERE_COORD_W-1:0] x;
        logic signed [SPHERE_COORD_W-1:0] y;
        logic signed [SPHERE_COORD_W-1:0] z;
        logic        [SPHERE_COORD_W-1:0] r;
    } Sphere;

    // 0 = no hit, k+1 = sphere k is the nearest hit.
    typedef logic [COLOR_W-1:0] Color;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PIXEL     = 4'd1,
        S_DOT       = 4'd2,
        S_QUAD      = 4'd3,
        S_DISC      = 4'd4,
        S_SQRT_REQ  = 4'd5,
        S_SQRT_WAIT = 4'd6,
        S_COMPARE   = 4'd7,
        S_WRITE     = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    // b^2 is roughly a 4*COORD_W-bit product; the extra 8 bits absorb the
    // factors of 2 and 4 and the three-term sums without overflow.
    function automatic int DISC_W(input int coord_w);
        return 4 * coord_w + 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ray_sphere_worker_sqrt.sv
`default_nettype none
// ============================================================================
// Module      : SquareRoot
// Description : Iterative integer square root, one result bit per cycle
//               (digit-by-digit, radix 4). root = floor(sqrt(radicand)).
// Ports       : clk, rst_ (async active-low), start (sampled while idle),
//               radicand [WIDTH], busy (high from the cycle after start until
//               the result is valid), root [WIDTH/2].
// Revision    : 1.0 - initial release
// ============================================================================
module SquareRoot #(
    parameter int WIDTH = 56
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               start,
    input  logic [WIDTH-1:0]   radicand,
    output logic               busy,
    output logic [WIDTH/2-1:0] root
);
    localparam int c_RW    = WIDTH / 2;
    // The remainder never exceeds 2*root, so RW+3 bits hold the shifted value.
    localparam int c_REM_W = c_RW + 3;
    localparam int c_CNT_W = $clog2(c_RW + 1);

    logic [WIDTH-1:0]   r_a;
    logic [c_RW-1:0]    r_root;
    logic [c_REM_W-1:0] r_rem;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;

    logic [c_REM_W-1:0] w_rem_sh;
    logic [c_REM_W-1:0] w_trial;
    logic               w_ge;

    // Bring down the next two radicand bits and try root digit 1.
    assign w_rem_sh = (r_rem << 2) | c_REM_W'(r_a[WIDTH-1 -: 2]);
    assign w_trial  = c_REM_W'({r_root, 2'b01});
    assign w_ge     = (w_rem_sh >= w_trial);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_a    <= '0;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (!r_busy) begin
            if (start) begin
                r_a    <= radicand;
                r_root <= '0;
                r_rem  <= '0;
                r_cnt  <= c_CNT_W'(c_RW);
                r_busy <= 1'b1;
            end
        end else begin
            r_a    <= r_a << 2;
            r_rem  <= w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
            r_root <= {r_root[c_RW-2:0], w_ge};
            r_cnt  <= r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign root = r_root;

endmodule
`default_nettype wire

// File: rtl/ray_sphere_worker.sv
`default_nettype none
// ============================================================================
// Module      : ray_sphere_worker
// Description : Casts one ray per pixel for a batch of JOBS pixels on a row
//               and records, per pixel, which of N_SPHERES spheres is hit
//               nearest (k+1) or 0 for no hit. Ray origin is the camera at
//               the origin; pixel p = (px, py, PIXEL_Z) is the ray direction.
// Ports       : clk, rst_ (async active-low), start, pixel_start_x, pixel_y,
//               spheres[N_SPHERES] (snapshotted at start), busy, done
//               (one-cycle pulse), buffer[JOBS] (per-pixel colour code).
// Revision    : 1.0 - initial release
// ============================================================================
module ray_sphere_worker
    import ray_sphere_worker_pkg::*;
#(
    parameter int N_SPHERES = 4,
    parameter int JOBS      = JOBS_SUBDIVISION,
    parameter int X_STRIDE  = N_WORKERS,
    parameter int COORD_W   = 12,
    parameter int PIXEL_Z   = 100
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] pixel_start_x,
    input  logic signed [COORD_W-1:0] pixel_y,
    input  Sphere [N_SPHERES-1:0]     spheres,
    output logic                      busy,
    output logic                      done,
    output Color  [JOBS-1:0]          buffer
);
    localparam int c_DW   = DISC_W(COORD_W);
    localparam int c_SW   = SPHERE_COORD_W;
    localparam int c_SI_W = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;
    localparam int c_JI_W = (JOBS > 1) ? $clog2(JOBS) : 1;
    localparam logic [c_SI_W-1:0] c_LAST_SPHERE = c_SI_W'(N_SPHERES - 1);
    localparam logic [c_JI_W-1:0] c_LAST_JOB    = c_JI_W'(JOBS - 1);

    state_t                    r_state;
    state_t                    w_next;

    logic signed [COORD_W-1:0] r_start_x;
    logic signed [COORD_W-1:0] r_py;
    Sphere [N_SPHERES-1:0]     r_spheres;
    logic [c_JI_W-1:0]         r_job;
    logic [c_SI_W-1:0]         r_sphere;

    logic signed [c_DW-1:0]    r_px;
    logic signed [c_DW-1:0]    r_a;
    logic signed [c_DW-1:0]    r_b;
    logic signed [c_DW-1:0]    r_c;
    logic signed [c_DW-1:0]    r_b2;
    logic signed [c_DW-1:0]    r_4ac;
    logic signed [c_DW-1:0]    r_disc;
    logic                      r_disc_neg;
    logic                      r_sqrt_seen;
    logic                      r_hit;
    logic signed [c_DW-1:0]    r_best_t;
    logic [c_SI_W-1:0]         r_best_idx;
    Color [JOBS-1:0]           r_buffer;

    logic                      w_sqrt_start;
    logic                      w_sqrt_busy;
    logic [c_DW/2-1:0]         w_sqrt_root;

    Sphere                     w_sph;
    logic signed [c_DW-1:0]    w_xk;
    logic signed [c_DW-1:0]    w_yk;
    logic signed [c_DW-1:0]    w_zk;
    logic signed [c_DW-1:0]    w_r8;
    logic signed [c_DW-1:0]    w_py;
    logic signed [c_DW-1:0]    w_pz;
    logic signed [c_DW-1:0]    w_sx;
    logic signed [c_DW-1:0]    w_job_ext;
    logic signed [c_DW-1:0]    w_stride;
    logic signed [c_DW-1:0]    w_px;
    logic signed [c_DW-1:0]    w_disc;
    logic signed [c_DW-1:0]    w_root_ext;
    logic signed [c_DW-1:0]    w_t_num;
    logic                      w_t_pos;
    logic                      w_better;

    // ------------------------------------------------------------------
    // Operand widening: everything is computed at the full DISC_W width.
    // ------------------------------------------------------------------
    assign w_sph      = r_spheres[r_sphere];
    assign w_xk       = {{(c_DW-c_SW){w_sph.x[c_SW-1]}}, w_sph.x};
    assign w_yk       = {{(c_DW-c_SW){w_sph.y[c_SW-1]}}, w_sph.y};
    assign w_zk       = {{(c_DW-c_SW){w_sph.z[c_SW-1]}}, w_sph.z};
    assign w_r8       = c_DW'({w_sph.r, 3'b000});
    assign w_py       = {{(c_DW-COORD_W){r_py[COORD_W-1]}}, r_py};
    assign w_pz       = c_DW'(PIXEL_Z);
    assign w_sx       = {{(c_DW-COORD_W){r_start_x[COORD_W-1]}}, r_start_x};
    assign w_job_ext  = c_DW'(r_job);
    assign w_stride   = c_DW'(X_STRIDE);
    assign w_px       = w_sx + w_job_ext * w_stride;

    assign w_disc     = r_b2 - r_4ac;

    // t_num = b - sqrt(disc). The true distance is t_num / 2a, and a is the
    // same for every sphere of one pixel, so comparing t_num is enough.
    assign w_root_ext = c_DW'(w_sqrt_root);
    assign w_t_num    = r_b - w_root_ext;
    assign w_t_pos    = !w_t_num[c_DW-1] && (w_t_num != '0);
    // Strict less-than keeps the lower sphere index on a tie.
    assign w_better   = !r_disc_neg && w_t_pos && (!r_hit || (w_t_num < r_best_t));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_sqrt_start = 1'b0;
        case (r_state)
            S_IDLE:      if (start) w_next = S_PIXEL;
            S_PIXEL:     w_next = S_DOT;
            S_DOT:       w_next = S_QUAD;
            S_QUAD:      w_next = S_DISC;
            S_DISC:      w_next = w_disc[c_DW-1] ? S_COMPARE : S_SQRT_REQ;
            S_SQRT_REQ: begin
                w_sqrt_start = 1'b1;
                w_next       = S_SQRT_WAIT;
            end
            // Only leave once the core has been seen busy, so a stale idle
            // level right after the request is not mistaken for completion.
            S_SQRT_WAIT: if (r_sqrt_seen && !w_sqrt_busy) w_next = S_COMPARE;
            S_COMPARE:   w_next = (r_sphere == c_LAST_SPHERE) ? S_WRITE : S_DOT;
            S_WRITE:     w_next = (r_job == c_LAST_JOB) ? S_DONE : S_PIXEL;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_start_x   <= '0;
            r_py        <= '0;
            r_spheres   <= '0;
            r_job       <= '0;
            r_sphere    <= '0;
            r_px        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_b2        <= '0;
            r_4ac       <= '0;
            r_disc      <= '0;
            r_disc_neg  <= 1'b0;
            r_sqrt_seen <= 1'b0;
            r_hit       <= 1'b0;
            r_best_t    <= '0;
            r_best_idx  <= '0;
            r_buffer    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_start_x <= pixel_start_x;
                        r_py      <= pixel_y;
                        r_spheres <= spheres;
                        r_job     <= '0;
                        r_sphere  <= '0;
                    end
                end
                S_PIXEL: begin
                    r_px     <= w_px;
                    r_a      <= w_px * w_px + w_py * w_py + w_pz * w_pz;
                    r_hit    <= 1'b0;
                    r_best_t <= '0;
                    if (r_job == '0) begin
                        r_buffer <= '0;
                    end
                end
                S_DOT: begin
                    r_b <= (r_px * w_xk + w_py * w_yk + w_pz * w_zk) <<< 1;
                    r_c <= w_xk * w_xk + w_yk * w_yk + w_zk * w_zk - w_r8 * w_r8;
                end
                S_QUAD: begin
                    r_b2  <= r_b * r_b;
                    r_4ac <= (r_a * r_c) <<< 2;
                end
                S_DISC: begin
                    r_disc     <= w_disc;
                    r_disc_neg <= w_disc[c_DW-1];
                end
                S_SQRT_REQ: begin
                    r_sqrt_seen <= 1'b0;
                end
                S_SQRT_WAIT: begin
                    if (w_sqrt_busy) begin
                        r_sqrt_seen <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (w_better) begin
                        r_hit      <= 1'b1;
                        r_best_t   <= w_t_num;
                        r_best_idx <= r_sphere;
                    end
                    r_sphere <= (r_sphere == c_LAST_SPHERE) ? '0 : r_sphere + c_SI_W'(1);
                end
                S_WRITE: begin
                    r_buffer[r_job] <= r_hit ? (Color'(r_best_idx) + Color'(1)) : '0;
                    r_job           <= (r_job == c_LAST_JOB) ? '0 : r_job + c_JI_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign buffer = r_buffer;

    // Negative discriminants never reach the core, so r_disc is a valid
    // unsigned radicand whenever a root is requested.
    SquareRoot #(
        .WIDTH    (c_DW)
    ) u_sqrt (
        .clk      (clk),
        .rst_     (rst_),
        .start    (w_sqrt_start),
        .radicand (r_disc),
        .busy     (w_sqrt_busy),
        .root     (w_sqrt_root)
    );

endmodule
`default_nettype wire

// File: tb/tb_ray_sphere_worker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ray_sphere_worker
// Description : Scoreboard bench for ray_sphere_worker. Each accepted start
//               pushes the colours predicted by a plain-arithmetic ray/sphere
//               model; a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ray_sphere_worker;
    import ray_sphere_worker_pkg::*;

    localparam int NS     = 4;
    localparam int NJ     = JOBS_SUBDIVISION;
    localparam int STRIDE = N_WORKERS;
    localparam int CW     = 12;
    localparam int PZ     = 100;

    typedef Sphere [NS-1:0] scene_t;
    typedef Color  [NJ-1:0] colors_t;
    typedef struct {
        colors_t colors;
        int      lat;
        int      acc;
    } exp_t;

    logic                 clk;
    logic                 rst_;
    logic                 start;
    logic signed [CW-1:0] pixel_start_x;
    logic signed [CW-1:0] pixel_y;
    scene_t               spheres;
    logic                 busy;
    logic                 done;
    colors_t              buffer;

    exp_t    exp_q[$];
    colors_t last_colors;
    int      errors = 0;
    int      checks = 0;
    int      cyc    = 0;

    ray_sphere_worker #(
        .N_SPHERES     (NS),
        .JOBS          (NJ),
        .X_STRIDE      (STRIDE),
        .COORD_W       (CW),
        .PIXEL_Z       (PZ)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .start         (start),
        .pixel_start_x (pixel_start_x),
        .pixel_y       (pixel_y),
        .spheres       (spheres),
        .busy          (busy),
        .done          (done),
        .buffer        (buffer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint isqrt(input longint v);
        longint s;
        s = longint'($sqrt(real'(v)));
        while (s * s > v) s--;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    // Ray from the origin through (px, py, PZ); nearest positive root wins,
    // lower index on ties.
    function automatic colors_t model(input int sx, input int py, input scene_t sc);
        colors_t res;
        for (int j = 0; j < NJ; j++) begin
            longint px, a, b, c, d, t, best_t, xk, yk, zk, rr;
            int     best;
            px = sx + j * STRIDE;
            a  = px * px + py * py + PZ * PZ;
            best = 0;
            best_t = 0;
            for (int k = 0; k < NS; k++) begin
                xk = $signed(sc[k].x);
                yk = $signed(sc[k].y);
                zk = $signed(sc[k].z);
                rr = longint'(sc[k].r) * 8;
                rr = rr * rr;
                b = 2 * (px * xk + py * yk + PZ * zk);
                c = xk * xk + yk * yk + zk * zk - rr;
                d = b * b - 4 * a * c;
                if (d >= 0) begin
                    t = b - isqrt(d);
                    if (t > 0 && (best == 0 || t < best_t)) begin
                        best   = k + 1;
                        best_t = t;
                    end
                end
            end
            res[j] = Color'(best);
        end
        return res;
    endfunction

    function automatic Sphere mk(input int x, input int y, input int z, input int r);
        Sphere s;
        s.x = 12'(x);
        s.y = 12'(y);
        s.z = 12'(z);
        s.r = 12'(r);
        return s;
    endfunction

    function automatic scene_t rand_scene();
        scene_t s;
        for (int k = 0; k < NS; k++) begin
            s[k] = mk(int'($urandom_range(600)) - 300, int'($urandom_range(600)) - 300,
                      int'($urandom_range(600)) - 200, int'($urandom_range(39)) + 1);
        end
        return s;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ && done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    for (int j = 0; j < NJ; j++) begin
                        check($sformatf("buffer[%0d]", j), 64'(buffer[j]), 64'(e.colors[j]));
                    end
                    check("busy_at_done", 64'(busy), 64'd0);
                    if (e.lat > 0) begin
                        check("miss_latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    // Called on a negedge. exp0 >= 0 adds a fixed expectation for pixel 0.
    task automatic run_batch(input string name, input int sx, input int py, input scene_t sc,
                             input int lat, input bit poke, input int exp0);
        exp_t e;
        pixel_start_x = CW'(sx);
        pixel_y       = CW'(py);
        spheres       = sc;
        start         = 1'b1;
        e.colors      = model(sx, py, sc);
        e.lat         = lat;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.acc = cyc;
        exp_q.push_back(e);
        last_colors = e.colors;
        check({name, "_busy_after_start"}, 64'(busy), 64'd1);
        if (poke) begin
            repeat (7) @(negedge clk);
            pixel_start_x = CW'(int'($urandom_range(100)) - 50);
            spheres       = rand_scene();
            start         = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain(name);
        if (exp0 >= 0) begin
            check({name, "_pixel0"}, 64'(buffer[0]), 64'(exp0));
        end
        pixel_start_x = CW'(int'($urandom_range(100)) - 50);
        spheres       = rand_scene();
        repeat (3) @(negedge clk);
        check({name, "_hold"}, 64'(buffer), 64'(last_colors));
    endtask

    task automatic reset_mid_batch();
        scene_t sc;
        int     n;
        for (int k = 0; k < NS; k++) sc[k] = mk(0, 0, 200, 10);
        pixel_start_x = CW'(-16);
        pixel_y       = '0;
        spheres       = sc;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(dut.r_job == 3'd3 && dut.r_state == S_SQRT_WAIT) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_job3_sqrt_wait", 64'(n < 3000), 64'd1);
        #2;
        rst_ = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_buffer", 64'(buffer), 64'd0);
        repeat (3) @(negedge clk);
        check("midrst_buffer_held", 64'(buffer), 64'd0);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_no_done", 64'(done), 64'd0);
        run_batch("after_reset", -16, 0, sc, 0, 1'b0, 1);
    endtask

    initial begin
        scene_t sc;
        Sphere  miss;
        rst_          = 1'b0;
        start         = 1'b0;
        pixel_start_x = '0;
        pixel_y       = '0;
        spheres       = '0;
        miss          = mk(500, 0, 200, 1);
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_buffer", 64'(buffer), 64'd0);

        // Start on the very first edge after reset release.
        rst_ = 1'b1;
        sc = {miss, miss, miss, mk(0, 0, 200, 10)};
        run_batch("single_hit", 0, 0, sc, 0, 1'b0, 1);

        sc = {miss, miss, miss, miss};
        run_batch("all_miss", 0, 0, sc, NJ * (2 + 4 * NS), 1'b0, 0);

        sc = {miss, miss, mk(0, 0, 200, 10), mk(0, 0, 400, 10)};
        run_batch("nearest", 0, 0, sc, 0, 1'b0, 2);

        sc = {miss, miss, mk(0, 0, 400, 10), mk(0, 0, 400, 10)};
        run_batch("tie", 0, 0, sc, 0, 1'b0, 1);

        sc = {miss, miss, miss, mk(0, 0, -200, 10)};
        run_batch("behind", 0, 0, sc, 0, 1'b0, 0);

        sc = {mk(-12, 0, 200, 3), mk(8, 0, 150, 4), mk(-4, 0, 300, 20), mk(-16, 0, 100, 2)};
        run_batch("row_stride", -16, 0, sc, 0, 1'b1, -1);

        reset_mid_batch();

        for (int i = 0; i < 10; i++) begin
            run_batch($sformatf("rand%0d", i), int'($urandom_range(128)) - 64,
                      int'($urandom_range(128)) - 64, rand_scene(), 0, i[0], -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ray_sphere_worker.md
RAY_SPHERE_WORKER -- requirements
Module: ray_sphere_worker

Interface
REQ-001 Parameter N_SPHERES, default 4: number of spheres tested per pixel.
REQ-002 Parameter JOBS, default JOBS_SUBDIVISION: pixels processed per start.
REQ-003 Parameter X_STRIDE, default N_WORKERS: x step between consecutive jobs.
REQ-004 Parameter COORD_W, default 12: signed pixel coordinate width.
REQ-005 Parameter PIXEL_Z, default 100: constant image-plane z.
REQ-006 One clock; reset is asynchronous and active-low; ports named clk and rst_.
REQ-007 Port clk, input, 1: rising-edge clock.
REQ-008 Port rst_, input, 1: asynchronous active-low reset.
REQ-009 Port start, input, 1: request a batch; sampled only in IDLE.
REQ-010 Port pixel_start_x, input, COORD_W signed: x of job 0.
REQ-011 Port pixel_y, input, COORD_W signed: y shared by all jobs.
REQ-012 Port spheres, input, Types::Sphere [N_SPHERES]: scene, snapshotted at accepted start.
REQ-013 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-014 Port done, output, 1: one-cycle pulse when the batch completes.
REQ-015 Port buffer, output, Types::Color [JOBS]: per-job colour; 0 = no hit, k+1 = sphere k nearest.

Function
REQ-016 Start accepted only in IDLE; latch pixel_start_x, pixel_y and all spheres; start while busy is ignored.
REQ-017 Job j uses px = pixel_start_x + j*X_STRIDE, py = pixel_y, pz = PIXEL_Z, all sign-extended, no truncation.
REQ-018 Per job: a = px^2 + py^2 + pz^2, computed once in state PIXEL.
REQ-019 Per sphere k: b = 2*(px*xk + py*yk + pz*zk); c = xk^2 + yk^2 + zk^2 - (rk<<3)^2; disc = b^2 - 4ac.
REQ-020 All intermediates held at full signed width (DISC_W = 4*COORD_W + 8); no overflow for legal inputs.
REQ-021 disc < 0: miss, skip sqrt; disc >= 0: start SquareRoot with A = disc.
REQ-022 t_num = b - sqrt(disc); hit only if t_num > 0; nearest hit = smallest t_num (a is common per pixel, so no divide).
REQ-023 Equal t_num: lower sphere index wins.
REQ-024 States: IDLE -> PIXEL -> DOT -> QUAD -> DISC -> (SQRT_REQ -> SQRT_WAIT ->) COMPARE -> next sphere (DOT) or WRITE -> next job (PIXEL) or DONE -> IDLE.
REQ-025 SQRT_REQ asserts sqrt_start one cycle; SQRT_WAIT leaves when the sqrt core reports busy low after it went high.
REQ-026 WRITE stores the nearest index+1, or 0, into buffer[j]; other entries are unchanged.
REQ-027 Job and sphere counters wrap to 0 after the last index; done asserts in DONE for exactly one cycle, busy drops in the same cycle.
REQ-028 buffer holds its values after done until the next accepted start, which clears all entries in PIXEL of job 0.
REQ-029 Miss-only sphere latency: DOT..COMPARE = 4 cycles; a hit adds 2 + sqrt latency.

Reset
REQ-030 rst_ low at any time: state IDLE, busy 0, done 0, buffer all 0, counters 0, sqrt_start 0, including mid-batch.
REQ-031 First start is accepted on the first clk edge after rst_ deasserts.

Structure
REQ-032 Types package holds Sphere, Color, JOBS_SUBDIVISION, N_WORKERS, and the DISC_W function.
REQ-033 One sub-module, SquareRoot, instantiated once and sized to DISC_W.

Verification
REQ-034 Sphere (0,0,200,r=10), px=py=0 -> disc=256000000, t_num=24000, buffer[0]=1.
REQ-035 Sphere (500,0,200,r=1), px=0 -> disc<0, sqrt not started, buffer[0]=0.
REQ-036 s0 (0,0,400,10) and s1 (0,0,200,10), px=0 -> buffer[0]=2; with s1 = copy of s0 -> buffer[0]=1 (tie rule).
REQ-037 Sphere (0,0,-200,10), px=0 -> t_num=-56000, buffer[0]=0 (behind camera).
REQ-038 JOBS=8, X_STRIDE=4, start_x=-16 -> px sequence -16..12 step 4, one done pulse, busy low afterwards.
REQ-039 rst_ low during SQRT_WAIT of job 3 -> IDLE, buffer 0, no done; the next start runs a full clean batch.
